pipe_stage_elastic: RTL

Parametrised successor to the fixed-field inter-stage pipeline latches. It holds one generic `WIDTH`-bit payload with a valid/ready handshake on both sides, so it can replace the hand-written IF/ID, ID/EX, EX/MEM and MEM/WB latches with one verified block. It supports a flush with an optional payload clear, an optional two-entry skid buffer that makes `in_ready` registered, and a saturating counter of entries discarded by flushes. Each instance sits between two pipeline stages. The hazard unit drives `flush`.

---
 rtl/pipe_stage_elastic.sv | 133 +++++++++++++
 1 files changed

// File: rtl/pipe_stage_elastic.sv
// pipe_stage_elastic
// Generic elastic pipeline stage: one WIDTH-bit payload with valid/ready on
// both sides, a flush with optional payload clear, and a saturating count of
// entries discarded by flushes.
//
// Build option: define PIPE_STAGE_SKID_EN to add a second (skid) entry, which
// makes in_ready a registered function of state. Without it the stage has a
// single entry and in_ready follows out_ready combinationally.
//
// Handshake: a transfer happens on a side in any cycle where valid and ready
// are both high at the rising edge of CLK. The producer holds valid/data
// stable until its transfer; valid never waits on ready.
module pipe_stage_elastic #(
  parameter int WIDTH          = 32,
  parameter int CLEAR_ON_FLUSH = 1,
  parameter int CNT_W          = 8
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [1:0]       occupancy,
  output logic [CNT_W-1:0] drop_cnt,
  output logic [1:0]       dbg_state
);

  // Encoding doubles as the entry count.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    FULL  = 2'd1,
    SKID  = 2'd2
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] main_q;
`ifdef PIPE_STAGE_SKID_EN
  logic [WIDTH-1:0] skid_q;
`endif
  logic [CNT_W-1:0] drop_q;

  logic             in_fire;
  logic             out_fire;
  logic [1:0]       drop_inc;
  logic [CNT_W+1:0] drop_sum;
  logic [CNT_W-1:0] drop_next;

  assign out_valid = (state != EMPTY);
  assign out_data  = main_q;
  assign occupancy = state;
  assign drop_cnt  = drop_q;
  assign dbg_state = state;

`ifdef PIPE_STAGE_SKID_EN
  // Only the state register decides readiness; RST/flush are the sole gates.
  assign in_ready = !RST && !flush && (state != SKID);
`else
  // Single entry: can take a new payload only if the held one leaves now.
  assign in_ready = !RST && !flush && ((state == EMPTY) || out_ready);
`endif

  assign in_fire  = in_valid && in_ready;
  assign out_fire = out_valid && out_ready;

  // Entries lost to a flush: everything held except one consumed this cycle.
  assign drop_inc  = occupancy - {1'b0, out_fire};
  assign drop_sum  = {2'b00, drop_q} + {{CNT_W{1'b0}}, drop_inc};
  assign drop_next = (drop_sum[CNT_W+1:CNT_W] != 2'b00) ? {CNT_W{1'b1}}
                                                       : drop_sum[CNT_W-1:0];

  // State, payload registers and drop counter; RST > flush > handshake.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state  <= EMPTY;
      main_q <= '0;
`ifdef PIPE_STAGE_SKID_EN
      skid_q <= '0;
`endif
      drop_q <= '0;
    end else if (flush) begin
      state  <= EMPTY;
      drop_q <= drop_next;
      if (CLEAR_ON_FLUSH != 0) begin
        main_q <= '0;
`ifdef PIPE_STAGE_SKID_EN
        skid_q <= '0;
`endif
      end
    end else begin
      case (state)
        EMPTY: begin
          if (in_fire) begin
            state  <= FULL;
            main_q <= in_data;
          end
        end
        FULL: begin
`ifdef PIPE_STAGE_SKID_EN
          if (in_fire && out_fire) begin
            main_q <= in_data;
          end else if (in_fire) begin
            state  <= SKID;
            skid_q <= in_data;
          end else if (out_fire) begin
            state <= EMPTY;
          end
`else
          // in_fire here implies out_fire: replace the consumed entry.
          if (in_fire) begin
            main_q <= in_data;
          end else if (out_fire) begin
            state <= EMPTY;
          end
`endif
        end
`ifdef PIPE_STAGE_SKID_EN
        SKID: begin
          if (out_fire) begin
            state  <= FULL;
            main_q <= skid_q;
          end
        end
`endif
        default: state <= EMPTY;
      endcase
    end
  end

endmodule
